core_mem_stage: RTL and testbench
=================================

CORE_MEM_STAGE -- requirements
Module: core_mem_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 Parameter CACHE_BASE, default 32'h0000_1000, first cacheable address; lower addresses are uncacheable.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ex_val  input  1  EX stage presents an instruction.
REQ-006 ex_rdy  output  1  stage accepts; transfer occurs when ex_val&&ex_rdy.
REQ-007 ex_kill  input  1  flush: discard held and in-flight instruction.
REQ-008 ex_op  input  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
REQ-009 ex_size  input  2  00 byte, 01 half, 10 word, 11 dword (XLEN=64 only).
REQ-010 ex_sext  input  1  load result sign-extended when 1.
REQ-011 ex_addr  input  XLEN  memory address, or ALU result when ex_op=none.
REQ-012 ex_wdata  input  XLEN  store data, LSB-aligned.
REQ-013 ex_rd / ex_we  input  5 / 1  destination register and write enable.
REQ-014 l1d_req_val  output  1  L1D request valid.
REQ-015 l1d_req_ack  input  1  L1D accepts request this cycle.
REQ-016 l1d_req_addr / l1d_req_wdata  output  XLEN / XLEN  address; store data replicated into byte lanes.
REQ-017 l1d_req_cop  output  3  {cacheable, op[1:0]}.
REQ-018 l1d_req_size / l1d_req_be  output  3 / XLEN/8  size; byte enables.
REQ-019 l1d_rsp_val / l1d_rsp_data  input  1 / XLEN  load response, one cycle pulse.
REQ-020 wb_val / wb_we / wb_rd / wb_data  output  1 / 1 / 5 / XLEN  registered writeback.
REQ-021 mem2haz_stall  output  1  high while a memory op is outstanding.

Function
REQ-022 FSM states IDLE, REQ, WAIT, DONE; IDLE accepts when ex_rdy=1 (ex_rdy=1 only in IDLE).
REQ-023 Accepted op=none: wb_val=1 next cycle with wb_data=ex_addr; FSM stays IDLE; latency 1.
REQ-024 Accepted load/store: IDLE->REQ; l1d_req_* registered and held stable until l1d_req_ack.
REQ-025 REQ with ack: store -> DONE; load -> WAIT; rsp_val in same cycle as ack is ignored (response earliest next cycle).
REQ-026 WAIT with l1d_rsp_val -> DONE; byte lane = addr[log2(XLEN/8)-1:0], extracted, zero/sign-extended per ex_size/ex_sext.
REQ-027 DONE: wb_val=1 for exactly one cycle (store: wb_we=0), then IDLE.
REQ-028 cacheable bit = (addr >= CACHE_BASE), unsigned compare.
REQ-029 be = size mask shifted by low address bits; misaligned bits ignored when CORE_MEM_MISALIGN_EN undefined.
REQ-030 mem2haz_stall = state in {REQ, WAIT}.
REQ-031 ex_kill in REQ: request withdrawn only if no ack that cycle; else FSM completes silently (no wb_val), WAIT response discarded; -> IDLE.
REQ-032 ex_kill and ex_val same cycle in IDLE: instruction not accepted.

Reset
REQ-033 rst: state IDLE, all outputs 0 except ex_rdy=1; rst mid-WAIT drops outstanding response.
REQ-034 Response arriving in IDLE after reset/kill is ignored.

Configuration
REQ-035 CORE_MEM_MISALIGN_EN defined: misaligned access skips L1D, goes to DONE with wb_val=1, wb_we=0 and added output excp_misalign=1 for one cycle; undefined: port absent, no check.

Structure
REQ-036 Package core_mem_pkg: op/size/state encodings, COP field positions, CACHE_BASE default.
REQ-037 Sub-module core_mem_ld_align: combinational lane extract and extension.

Verification
REQ-038 op=none, addr=0x1234 -> wb_val next cycle, wb_data=0x1234, no l1d_req_val.
REQ-039 Load byte sext, addr=0x2003, rsp_data=0x80AA_BBCC -> wb_data=0xFFFF_FF80.
REQ-040 Store half addr=0x0802, wdata=0xBEEF, ack after 3 cycles -> req held 3 cycles, be=4'b1100, cop=3'b010, stall high throughout.
REQ-041 Load accepted, kill in WAIT, rsp next cycle -> no wb_val, FSM IDLE, ex_rdy=1.
REQ-042 Macro on, word load addr=0x2002 -> no l1d_req_val, excp_misalign pulse, wb_we=0.

Source files
------------

// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared encodings for the memory stage
// Holds op/size/state encodings, COP field positions and the cacheable base default.
package core_mem_pkg;
    typedef enum logic [1:0] {OP_NONE = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_RSVD = 2'b11} op_e;
    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
    localparam int COP_CACHE = 2;
    localparam int COP_OP_LSB = 0;
    localparam logic [31:0] CACHE_BASE_DEF = 32'h0000_1000;
endpackage

// File: rtl/core_mem_ld_align.sv
// core_mem_ld_align: extracts the addressed load lane and zero/sign-extends it
// Ports: data_i raw L1D word, off_i byte offset, size_i access size, sext_i sign-extend,
//        data_o aligned and extended result.
module core_mem_ld_align #(
    parameter int XLEN = 32,
    parameter int LB = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [LB-1:0]   off_i,
    input  logic [1:0]      size_i,
    input  logic            sext_i,
    output logic [XLEN-1:0] data_o
);
    logic [XLEN-1:0] sh, msk;
    assign sh = data_i >> {off_i, 3'b000};
    // a full-width access overflows the shift to zero, so the mask wraps to all ones
    assign msk = (XLEN'(1) << (7'd8 << size_i)) - XLEN'(1);
    // msk & ~(msk >> 1) isolates the sign bit of the accessed field
    assign data_o = (sh & msk) | ((sext_i && |(sh & msk & ~(msk >> 1))) ? ~msk : '0);
endmodule

// File: rtl/core_mem_stage.sv
// core_mem_stage: pipeline memory stage bridging EX to the L1D and writeback
// Ports: ex_* instruction from EX (ex_rdy handshake, ex_kill flush), l1d_req_* registered
//        request held until l1d_req_ack, l1d_rsp_* one-cycle load response, wb_* registered
//        writeback, mem2haz_stall while a request or response is outstanding.
// CORE_MEM_MISALIGN_EN: adds excp_misalign and completes misaligned accesses without the L1D.
module core_mem_stage
    import core_mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] CACHE_BASE = XLEN'(CACHE_BASE_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_val,
    output logic              ex_rdy,
    input  logic              ex_kill,
    input  logic [1:0]        ex_op,
    input  logic [1:0]        ex_size,
    input  logic              ex_sext,
    input  logic [XLEN-1:0]   ex_addr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [4:0]        ex_rd,
    input  logic              ex_we,
    output logic              l1d_req_val,
    input  logic              l1d_req_ack,
    output logic [XLEN-1:0]   l1d_req_addr,
    output logic [XLEN-1:0]   l1d_req_wdata,
    output logic [2:0]        l1d_req_cop,
    output logic [2:0]        l1d_req_size,
    output logic [XLEN/8-1:0] l1d_req_be,
    input  logic              l1d_rsp_val,
    input  logic [XLEN-1:0]   l1d_rsp_data,
    output logic              wb_val,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
`ifdef CORE_MEM_MISALIGN_EN
    output logic              excp_misalign,
`endif
    output logic              mem2haz_stall
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    state_e state_q;
    logic [XLEN-1:0] addr_q, wdata_q, wb_data_q, wdata_d, ld_data;
    logic [2:0] cop_q;
    logic [1:0] size_q;
    logic [NB-1:0] be_q, be_d;
    logic [4:0] rd_q, wb_rd_q;
    logic sext_q, we_q, drop_q, wb_val_q, wb_we_q, accept, is_mem, ld_q;
    assign ex_rdy = state_q == S_IDLE;
    assign accept = ex_val && ex_rdy && !ex_kill;
    assign is_mem = ex_op == OP_LOAD || ex_op == OP_STORE;
    assign ld_q = cop_q[COP_OP_LSB +: 2] == OP_LOAD;
    assign mem2haz_stall = state_q == S_REQ || state_q == S_WAIT;
    assign l1d_req_val = state_q == S_REQ;
    assign l1d_req_addr = addr_q;
    assign l1d_req_wdata = wdata_q;
    assign l1d_req_cop = cop_q;
    assign l1d_req_size = {1'b0, size_q};
    assign l1d_req_be = be_q;
    assign wb_val = wb_val_q;
    assign wb_we = wb_we_q;
    assign wb_rd = wb_rd_q;
    assign wb_data = wb_data_q;
    // replicate the LSB-aligned store data into every lane of its size
    assign wdata_d = ex_size == SZ_B ? {NB{ex_wdata[7:0]}} :
                     ex_size == SZ_H ? {(NB/2){ex_wdata[15:0]}} :
                     ex_size == SZ_W ? {(XLEN/32){ex_wdata[31:0]}} : ex_wdata;
    assign be_d = NB'((NB'(1) << (4'd1 << ex_size)) - NB'(1)) << ex_addr[LB-1:0];
`ifdef CORE_MEM_MISALIGN_EN
    logic excp_q, misal;
    logic [LB-1:0] amask;
    assign amask = LB'((4'd1 << ex_size) - 4'd1);
    assign misal = |(ex_addr[LB-1:0] & amask);
    assign excp_misalign = excp_q;
`endif
    core_mem_ld_align #(.XLEN(XLEN), .LB(LB)) u_align (
        .data_i (l1d_rsp_data),
        .off_i  (addr_q[LB-1:0]),
        .size_i (size_q),
        .sext_i (sext_q),
        .data_o (ld_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            cop_q <= '0;
            size_q <= '0;
            be_q <= '0;
            sext_q <= 1'b0;
            we_q <= 1'b0;
            rd_q <= '0;
            drop_q <= 1'b0;
            wb_val_q <= 1'b0;
            wb_we_q <= 1'b0;
            wb_rd_q <= '0;
            wb_data_q <= '0;
`ifdef CORE_MEM_MISALIGN_EN
            excp_q <= 1'b0;
`endif
        end else begin
            wb_val_q <= 1'b0;
`ifdef CORE_MEM_MISALIGN_EN
            excp_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: if (accept) begin
                    rd_q <= ex_rd;
                    we_q <= ex_we;
                    if (!is_mem) begin
                        wb_val_q <= 1'b1;
                        wb_we_q <= ex_we;
                        wb_rd_q <= ex_rd;
                        wb_data_q <= ex_addr;
`ifdef CORE_MEM_MISALIGN_EN
                    end else if (misal) begin
                        state_q <= S_DONE;
                        wb_val_q <= 1'b1;
                        wb_we_q <= 1'b0;
                        wb_rd_q <= ex_rd;
                        excp_q <= 1'b1;
`endif
                    end else begin
                        state_q <= S_REQ;
                        addr_q <= ex_addr;
                        wdata_q <= wdata_d;
                        cop_q[COP_CACHE] <= ex_addr >= CACHE_BASE;
                        cop_q[COP_OP_LSB +: 2] <= ex_op;
                        size_q <= ex_size;
                        be_q <= be_d;
                        sext_q <= ex_sext;
                        drop_q <= 1'b0;
                    end
                end
                // once acked the L1D owns the access; a kill only suppresses its writeback
                S_REQ: if (l1d_req_ack) begin
                    state_q <= ld_q ? S_WAIT : ex_kill ? S_IDLE : S_DONE;
                    drop_q <= ex_kill;
                    wb_val_q <= !ld_q && !ex_kill;
                    wb_we_q <= 1'b0;
                    wb_rd_q <= rd_q;
                end else if (ex_kill) begin
                    state_q <= S_IDLE;
                end
                // a killed load still waits for its response so it cannot land on a later load
                S_WAIT: if (l1d_rsp_val) begin
                    state_q <= (drop_q || ex_kill) ? S_IDLE : S_DONE;
                    wb_val_q <= !(drop_q || ex_kill);
                    wb_we_q <= we_q;
                    wb_rd_q <= rd_q;
                    wb_data_q <= ld_data;
                end else if (ex_kill) begin
                    drop_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_mem_stage.sv
// tb_core_mem_stage: directed scoreboard bench for core_mem_stage
module tb_core_mem_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic ex_val = 0, ex_kill = 0, ex_sext = 0, ex_we = 0;
    logic [1:0] ex_op = 0, ex_size = 0;
    logic [31:0] ex_addr = 0, ex_wdata = 0, l1d_rsp_data = 0, l1d_req_addr, l1d_req_wdata, wb_data;
    logic [4:0] ex_rd = 0, wb_rd;
    logic l1d_req_ack = 0, l1d_rsp_val = 0, ex_rdy, l1d_req_val, wb_val, wb_we, mem2haz_stall;
    logic [2:0] l1d_req_cop, l1d_req_size;
    logic [3:0] l1d_req_be;
`ifdef CORE_MEM_MISALIGN_EN
    logic excp_misalign;
`endif
    typedef struct {logic we; logic [4:0] rd; logic [31:0] data; logic chkd;} exp_t;
    exp_t sb[$];
    exp_t e;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    core_mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .ex_val(ex_val), .ex_rdy(ex_rdy), .ex_kill(ex_kill),
        .ex_op(ex_op), .ex_size(ex_size), .ex_sext(ex_sext), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_we(ex_we),
        .l1d_req_val(l1d_req_val), .l1d_req_ack(l1d_req_ack), .l1d_req_addr(l1d_req_addr),
        .l1d_req_wdata(l1d_req_wdata), .l1d_req_cop(l1d_req_cop), .l1d_req_size(l1d_req_size),
        .l1d_req_be(l1d_req_be), .l1d_rsp_val(l1d_rsp_val), .l1d_rsp_data(l1d_rsp_data),
        .wb_val(wb_val), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef CORE_MEM_MISALIGN_EN
        .excp_misalign(excp_misalign),
`endif
        .mem2haz_stall(mem2haz_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic we);
        ex_val = 1; ex_op = op; ex_size = size; ex_sext = sext;
        ex_addr = addr; ex_wdata = wdata; ex_rd = rd; ex_we = we;
        cyc();
        ex_val = 0;
    endtask

    task automatic expect_wb(input logic we, input logic [4:0] rd, input logic [31:0] data, input logic chkd);
        sb.push_back('{we, rd, data, chkd});
    endtask

    always @(negedge clk) begin
        if (!rst && wb_val) begin
            if (sb.size() == 0) chk("wb_unexpected", {63'b0, wb_val}, 64'd0);
            else begin
                e = sb.pop_front();
                chk("wb_we", {63'b0, wb_we}, {63'b0, e.we});
                chk("wb_rd", {59'b0, wb_rd}, {59'b0, e.rd});
                if (e.chkd) chk("wb_data", {32'b0, wb_data}, {32'b0, e.data});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(); cyc();
        chk("rst_rdy", ex_rdy, 1);
        chk("rst_req_val", l1d_req_val, 0);
        chk("rst_wb_val", wb_val, 0);
        chk("rst_stall", mem2haz_stall, 0);
        chk("rst_req_addr", l1d_req_addr, 0);
        rst = 0;
        expect_wb(1, 5'd5, 32'h1234, 1);
        drive(2'b00, 2'b10, 0, 32'h1234, 0, 5'd5, 1);
        chk("none_wbval", wb_val, 1);
        chk("none_noreq", l1d_req_val, 0);
        chk("none_rdy", ex_rdy, 1);
        cyc();
        drive(2'b01, 2'b00, 1, 32'h2003, 0, 5'd7, 1);
        chk("ld_req_val", l1d_req_val, 1);
        chk("ld_addr", l1d_req_addr, 32'h2003);
        chk("ld_cop", l1d_req_cop, 3'b101);
        chk("ld_be", l1d_req_be, 4'b1000);
        chk("ld_size", l1d_req_size, 3'b000);
        chk("ld_stall", mem2haz_stall, 1);
        chk("ld_rdy", ex_rdy, 0);
        l1d_req_ack = 1; cyc(); l1d_req_ack = 0;
        chk("ld_wait_req", l1d_req_val, 0);
        chk("ld_wait_stall", mem2haz_stall, 1);
        expect_wb(1, 5'd7, 32'hFFFF_FF80, 1);
        l1d_rsp_val = 1; l1d_rsp_data = 32'h80AA_BBCC; cyc(); l1d_rsp_val = 0;
        chk("ld_done_wbval", wb_val, 1);
        chk("ld_done_stall", mem2haz_stall, 0);
        cyc();
        chk("ld_idle_rdy", ex_rdy, 1);
        drive(2'b01, 2'b10, 0, 32'h0000_0004, 0, 5'd9, 1);
        chk("ldu_cop", l1d_req_cop, 3'b001);
        l1d_req_ack = 1; l1d_rsp_val = 1; l1d_rsp_data = 32'hDEAD_0000; cyc();
        l1d_req_ack = 0; l1d_rsp_val = 0;
        cyc();
        chk("ackrsp_stall", mem2haz_stall, 1);
        chk("ackrsp_wbval", wb_val, 0);
        expect_wb(1, 5'd9, 32'h1234_5678, 1);
        l1d_rsp_val = 1; l1d_rsp_data = 32'h1234_5678; cyc(); l1d_rsp_val = 0;
        cyc();
        drive(2'b01, 2'b01, 0, 32'h1002, 0, 5'd2, 1);
        chk("lh_be", l1d_req_be, 4'b1100);
        l1d_req_ack = 1; cyc(); l1d_req_ack = 0;
        expect_wb(1, 5'd2, 32'h0000_80AA, 1);
        l1d_rsp_val = 1; l1d_rsp_data = 32'h80AA_BBCC; cyc(); l1d_rsp_val = 0;
        cyc();
        expect_wb(0, 5'd3, 0, 0);
        drive(2'b10, 2'b01, 0, 32'h0802, 32'h0000_BEEF, 5'd3, 1);
        for (int i = 0; i < 3; i++) begin
            chk("st_req_val", l1d_req_val, 1);
            chk("st_addr", l1d_req_addr, 32'h0802);
            chk("st_be", l1d_req_be, 4'b1100);
            chk("st_cop", l1d_req_cop, 3'b010);
            chk("st_wdata", l1d_req_wdata, 32'hBEEF_BEEF);
            chk("st_size", l1d_req_size, 3'b001);
            chk("st_stall", mem2haz_stall, 1);
            if (i == 2) l1d_req_ack = 1;
            cyc();
        end
        l1d_req_ack = 0;
        chk("st_after_req", l1d_req_val, 0);
        chk("st_after_stall", mem2haz_stall, 0);
        chk("st_wbval", wb_val, 1);
        cyc();
        drive(2'b01, 2'b10, 0, 32'h3000, 0, 5'd4, 1);
        l1d_req_ack = 1; cyc(); l1d_req_ack = 0;
        ex_kill = 1; cyc(); ex_kill = 0;
        l1d_rsp_val = 1; l1d_rsp_data = 32'h5555_AAAA; cyc(); l1d_rsp_val = 0;
        chk("kw_wbval", wb_val, 0);
        chk("kw_rdy", ex_rdy, 1);
        chk("kw_stall", mem2haz_stall, 0);
        cyc();
        drive(2'b01, 2'b10, 0, 32'h3004, 0, 5'd8, 1);
        ex_kill = 1; cyc(); ex_kill = 0;
        chk("kr_req", l1d_req_val, 0);
        chk("kr_rdy", ex_rdy, 1);
        l1d_rsp_val = 1; cyc(); l1d_rsp_val = 0;
        chk("kr_idle_rsp", wb_val, 0);
        cyc();
        drive(2'b10, 2'b10, 0, 32'h3008, 32'h1, 5'd1, 0);
        ex_kill = 1; l1d_req_ack = 1; cyc(); ex_kill = 0; l1d_req_ack = 0;
        chk("ka_wbval", wb_val, 0);
        chk("ka_req", l1d_req_val, 0);
        cyc();
        chk("ka_rdy", ex_rdy, 1);
        ex_val = 1; ex_kill = 1; ex_op = 2'b00; ex_addr = 32'h55; cyc();
        ex_val = 0; ex_kill = 0;
        chk("kv_wbval", wb_val, 0);
        drive(2'b01, 2'b10, 0, 32'h2000, 0, 5'd10, 1);
        l1d_req_ack = 1; cyc(); l1d_req_ack = 0;
        rst = 1; cyc(); rst = 0;
        chk("rw_rdy", ex_rdy, 1);
        chk("rw_stall", mem2haz_stall, 0);
        l1d_rsp_val = 1; cyc(); l1d_rsp_val = 0;
        chk("rw_wbval", wb_val, 0);
`ifdef CORE_MEM_MISALIGN_EN
        expect_wb(0, 5'd6, 0, 0);
        drive(2'b01, 2'b10, 0, 32'h2002, 0, 5'd6, 1);
        chk("ma_req", l1d_req_val, 0);
        chk("ma_excp", excp_misalign, 1);
        chk("ma_wbval", wb_val, 1);
        cyc();
        chk("ma_excp_off", excp_misalign, 0);
        chk("ma_rdy", ex_rdy, 1);
`else
        drive(2'b01, 2'b10, 0, 32'h2002, 0, 5'd6, 1);
        chk("nm_req", l1d_req_val, 1);
        chk("nm_be", l1d_req_be, 4'b1100);
        l1d_req_ack = 1; cyc(); l1d_req_ack = 0;
        expect_wb(1, 5'd6, 0, 0);
        l1d_rsp_val = 1; cyc(); l1d_rsp_val = 0;
`endif
        cyc(); cyc();
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
